// File: rtl/spi_reg_pwm_bank.sv
// Bank of PWM channels configured from a 400-bit SPI register image.
// The image is staged on every SPI frame end; each channel adopts it at its own period boundary.
module spi_reg_pwm_bank #(
   parameter int NUM_CH  = 12,
   parameter int CLK_DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs,
   input  logic [399:0]      reg_bits,
   output logic [NUM_CH-1:0] pwm_out,
   output logic [NUM_CH-1:0] update_pending,
   output logic [7:0]        frame_count
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic          cs_s1;
   logic          cs_s2;
   logic          frame_end;
   logic          tick;
   logic [PW-1:0] presc;

   logic [15:0]       stg_p [NUM_CH];
   logic [15:0]       stg_d [NUM_CH];
   logic [NUM_CH-1:0] stg_e;
   logic [15:0]       act_p [NUM_CH];
   logic [15:0]       act_d [NUM_CH];
   logic [NUM_CH-1:0] act_e;
   logic [15:0]       cnt   [NUM_CH];
   logic [NUM_CH-1:0] load;

   // Reserved bits and slots of absent channels are intentionally not decoded.
   logic unused_bits;
   assign unused_bits = ^reg_bits;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_s1       <= 1'b1;
         cs_s2       <= 1'b1;
         frame_count <= '0;
      end else begin
         cs_s1 <= cs;
         cs_s2 <= cs_s1;
         if (frame_end) frame_count <= frame_count + 8'd1;
      end
   end

   assign frame_end = cs_s1 & ~cs_s2;
   assign tick      = (presc == PW'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    presc <= '0;
      else if (tick) presc <= '0;
      else           presc <= presc + PW'(1);
   end

   // A disabled channel has no period, so any pending config is taken on every tick.
   always_comb begin
      load = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         load[i] = tick & update_pending[i] & (~act_e[i] | (cnt[i] >= act_p[i]));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            stg_p[i] <= '0;
            stg_d[i] <= '0;
            act_p[i] <= '0;
            act_d[i] <= '0;
            cnt[i]   <= '0;
         end
         stg_e          <= '0;
         act_e          <= '0;
         update_pending <= '0;
         pwm_out        <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (tick) begin
               if (act_e[i] && (cnt[i] < act_p[i])) cnt[i] <= cnt[i] + 16'd1;
               else                                 cnt[i] <= '0;
            end
            if (load[i]) begin
               act_p[i] <= stg_p[i];
               act_d[i] <= stg_d[i];
               act_e[i] <= stg_e[i];
            end
            // A new snapshot in the same cycle as a load re-arms pending for the next boundary.
            if (frame_end) begin
               stg_p[i]          <= reg_bits[32*i +: 16];
               stg_d[i]          <= reg_bits[32*i+16 +: 16];
               stg_e[i]          <= reg_bits[384+i];
               update_pending[i] <= 1'b1;
            end else if (load[i]) begin
               update_pending[i] <= 1'b0;
            end
            pwm_out[i] <= act_e[i] & (cnt[i] < act_d[i]);
         end
      end
   end

endmodule

// File: tb/tb_spi_reg_pwm_bank.sv
// Directed bench for spi_reg_pwm_bank: frame sync, PWM timing, staged updates and reset.
module tb_spi_reg_pwm_bank;

   logic         clk;
   logic         rst_n;
   logic         cs;
   logic [399:0] reg_bits;
   logic [11:0]  pwm_out;
   logic [11:0]  update_pending;
   logic [7:0]   frame_count;

   int errors = 0;
   int checks = 0;
   int exp_fc = 0;

   spi_reg_pwm_bank #(.NUM_CH(12), .CLK_DIV(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cs             (cs),
      .reg_bits       (reg_bits),
      .pwm_out        (pwm_out),
      .update_pending (update_pending),
      .frame_count    (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic set_ch(input int ch, input logic [15:0] p, input logic [15:0] d, input logic e);
      reg_bits[32*ch +: 16]    = p;
      reg_bits[32*ch+16 +: 16] = d;
      reg_bits[384+ch]         = e;
   endtask

   task automatic frame();
      @(negedge clk) cs = 1'b0;
      repeat (2) @(negedge clk);
      cs = 1'b1;
      repeat (3) @(negedge clk);
      exp_fc++;
   endtask

   task automatic wait_rise(input int ch, input string tag);
      logic prev;
      int   n;
      prev = pwm_out[ch];
      n    = 0;
      forever begin
         @(negedge clk);
         n++;
         if (!prev && pwm_out[ch]) break;
         prev = pwm_out[ch];
         if (n >= 200) begin
            check(tag, 32'd0, 32'd1);
            break;
         end
      end
   endtask

   task automatic measure(input int ch, input logic lvl, output int n);
      n = 0;
      while (pwm_out[ch] == lvl && n < 500) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic count_high(input int ch, input int cycles, output int hi);
      hi = 0;
      repeat (cycles) begin
         @(negedge clk);
         if (pwm_out[ch]) hi++;
      end
   endtask

   initial begin
      int n;
      int hi;
      rst_n    = 1'b0;
      cs       = 1'b1;
      reg_bits = '0;
      reg_bits[399:396] = 4'hF;

      repeat (3) @(negedge clk);
      check("rst_pwm", 32'(pwm_out), 32'd0);
      check("rst_pend", 32'(update_pending), 32'd0);
      check("rst_fc", 32'(frame_count), 32'd0);
      rst_n = 1'b1;

      // first frame with ch0 P=9 D=3 E=1, checking sync latency
      set_ch(0, 16'd9, 16'd3, 1'b1);
      @(negedge clk) cs = 1'b0;
      repeat (2) @(negedge clk);
      cs = 1'b1;
      @(negedge clk);
      check("fc_lat1", 32'(frame_count), 32'd0);
      @(negedge clk);
      exp_fc++;
      check("fc_lat2", 32'(frame_count), 32'd1);
      check("pend_all", 32'(update_pending), 32'hFFF);
      for (int k = 0; k < 4; k++) begin
         if (update_pending == 12'h000) break;
         @(negedge clk);
      end
      check("pend_clear", 32'(update_pending), 32'd0);

      wait_rise(0, "rise0_timeout");
      measure(0, 1'b1, n); check("d3_high", n, 12);
      measure(0, 1'b0, n); check("d3_low", n, 28);
      measure(0, 1'b1, n); check("d3_high2", n, 12);

      // mid-period rewrite D=7 while high
      wait_rise(0, "rise1_timeout");
      set_ch(0, 16'd9, 16'd7, 1'b1);
      n = 1;
      for (int step = 1; step < 500; step++) begin
         if (step == 1) cs = 1'b0;
         if (step == 3) cs = 1'b1;
         @(negedge clk);
         if (!pwm_out[0]) break;
         n++;
      end
      exp_fc++;
      check("mid_high_old", n, 12);
      check("mid_pend", 32'(update_pending[0]), 32'd1);
      check("mid_fc", 32'(frame_count), 32'(exp_fc));
      measure(0, 1'b0, n); check("mid_low_old", n, 28);
      measure(0, 1'b1, n); check("d7_high", n, 28);
      check("d7_pend", 32'(update_pending[0]), 32'd0);
      measure(0, 1'b0, n); check("d7_low", n, 12);

      // ch1 boundary duty cases
      set_ch(1, 16'd9, 16'd0, 1'b1);
      frame();
      repeat (50) @(negedge clk);
      count_high(1, 60, hi); check("ch1_d0", hi, 0);
      set_ch(1, 16'd9, 16'd20, 1'b1);
      frame();
      repeat (50) @(negedge clk);
      count_high(1, 60, hi); check("ch1_d20", hi, 60);
      set_ch(1, 16'd9, 16'd20, 1'b0);
      frame();
      repeat (50) @(negedge clk);
      count_high(1, 60, hi); check("ch1_dis", hi, 0);
      check("ch1_cnt", 32'(dut.cnt[1]), 32'd0);

      // snapshot B lands in the same clk as the wrap that applies A
      wait_rise(0, "rise2_timeout");
      for (int k = 1; k <= 37; k++) begin
         @(negedge clk);
         if (k == 1)  set_ch(0, 16'd9, 16'd2, 1'b1);
         if (k == 2)  cs = 1'b0;
         if (k == 4)  cs = 1'b1;
         if (k == 10) begin
            exp_fc++;
            set_ch(0, 16'd9, 16'd5, 1'b1);
         end
         if (k == 20) check("a_pend", 32'(update_pending[0]), 32'd1);
         if (k == 30) cs = 1'b0;
         if (k == 37) cs = 1'b1;
      end
      @(negedge clk);
      check("ab_fc_before", 32'(frame_count), 32'(exp_fc));
      @(negedge clk);
      exp_fc++;
      check("ab_fc_after", 32'(frame_count), 32'(exp_fc));
      check("ab_pend", 32'(update_pending[0]), 32'd1);
      @(negedge clk);
      check("ab_rise", 32'(pwm_out[0]), 32'd1);
      measure(0, 1'b1, n); check("a_high", n, 8);
      measure(0, 1'b0, n); check("a_low", n, 32);
      measure(0, 1'b1, n); check("b_high", n, 20);
      check("b_pend", 32'(update_pending[0]), 32'd0);

      // frame counter wrap
      while ((exp_fc % 256) != 0) frame();
      check("fc_wrap", 32'(frame_count), 32'd0);

      // asynchronous reset while ch0 is high
      wait_rise(0, "rise3_timeout");
      @(negedge clk);
      check("pre_rst_pwm", 32'(pwm_out[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_pwm", 32'(pwm_out), 32'd0);
      check("arst_pend", 32'(update_pending), 32'd0);
      check("arst_fc", 32'(frame_count), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (50) @(negedge clk);
      check("post_rst_pwm", 32'(pwm_out), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
